// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder -- instruction decoder of the Jac1-8 8-bit CPU core.
//
// Splits the 16-bit program word into opcode, register selects and an 8-bit
// literal. Drives register-file read/write enables, the write-data source
// select, status-register write control and conditional relative-branch
// control for the program counter. Every decode output is combinational
// from instruction/status. The only state is the sticky illegal_op flag.
//
// Ports:
//   clk                     in   system clock (illegal_op only)
//   rst_n                   in   asynchronous active-low reset
//   instruction             in   current program word
//   status                  in   current status register
//                                (carry, underflow, zero, equal, gt, st)
//   opcode                  out  instruction[15:11]
//   param, literal_adr      out  instruction[7:0]
//   rd_sel1/2, rd_en1/2     out  register read selects / enables
//   wr_en, wr_sel           out  register write enable / select
//   sel_reg_in_alu_decoder  out  1 = write data from ALU, 0 = from param
//   add_offset              out  PC load is relative (PC + literal)
//   cnt_wr_en               out  PC load enable
//   stat_wr_en              out  status register write enable
//   stat_reg_in_alu_decoder out  status source: 1 = ALU, 0 = status_out
//   status_out              out  decoder-supplied status value
//   illegal_op              out  sticky flag, a reserved opcode was executed
// ---------------------------------------------------------------------------
module decoder #(
  parameter int DataWidth         = 8,
  parameter int SEL_WIDTH         = 2,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int ParamBits         = 8,
  parameter int NumStatusBits     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic [NumStatusBits-1:0]     status,
  output logic [NumOpCodeBits-1:0]     opcode,
  output logic [ParamBits-1:0]         param,
  output logic [DataWidth-1:0]         literal_adr,
  output logic [SEL_WIDTH-1:0]         rd_sel1,
  output logic [SEL_WIDTH-1:0]         rd_sel2,
  output logic                         rd_en1,
  output logic                         rd_en2,
  output logic                         wr_en,
  output logic [SEL_WIDTH-1:0]         wr_sel,
  output logic                         sel_reg_in_alu_decoder,
  output logic                         add_offset,
  output logic                         cnt_wr_en,
  output logic                         stat_wr_en,
  output logic                         stat_reg_in_alu_decoder,
  output logic [NumStatusBits-1:0]     status_out,
  output logic                         illegal_op
);

  // Opcode map
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_SHR  = 5'b01000;
  localparam logic [4:0] OP_VAL  = 5'b01001;
  localparam logic [4:0] OP_CMPR = 5'b01010;
  localparam logic [4:0] OP_GOTO = 5'b10000;
  localparam logic [4:0] OP_IFZ  = 5'b10001;
  localparam logic [4:0] OP_IFNZ = 5'b10010;
  localparam logic [4:0] OP_IFEQ = 5'b10011;
  localparam logic [4:0] OP_IFST = 5'b10100;
  localparam logic [4:0] OP_IFGT = 5'b10101;

  // Status bit positions
  localparam int ST_ZERO  = 2;
  localparam int ST_EQUAL = 3;
  localparam int ST_GT    = 4;
  localparam int ST_ST    = 5;

  logic [SEL_WIDTH-1:0] op1_s;
  logic [SEL_WIDTH-1:0] op2_s;
  logic                 reserved_s;
  logic                 illegal_op_d;
  logic                 illegal_op_q;

  // Field extraction, pass-through of opcode and immediate
  always_comb begin
    opcode      = instruction[15:11];
    param       = instruction[7:0];
    literal_adr = instruction[7:0];
    op1_s       = instruction[9:8];
    op2_s       = instruction[4:3];
  end

  // Main decode: defaults first, each opcode overrides only what it uses
  always_comb begin
    rd_sel1                 = 2'b00;
    rd_sel2                 = 2'b00;
    rd_en1                  = 1'b0;
    rd_en2                  = 1'b0;
    wr_en                   = 1'b0;
    wr_sel                  = 2'b00;
    sel_reg_in_alu_decoder  = 1'b0;
    add_offset              = 1'b0;
    cnt_wr_en               = 1'b0;
    stat_wr_en              = 1'b0;
    stat_reg_in_alu_decoder = 1'b1;
    status_out              = 6'b000000;
    reserved_s              = 1'b0;
    case (opcode)
      OP_NOP: begin
        reserved_s = 1'b0;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        rd_sel1                = op1_s;
        rd_sel2                = op2_s;
        rd_en1                 = 1'b1;
        rd_en2                 = 1'b1;
        wr_en                  = 1'b1;
        wr_sel                 = op1_s;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      // Unary: the operand comes through read port 2 only
      OP_NOT: begin
        rd_sel2                = op2_s;
        rd_en2                 = 1'b1;
        wr_en                  = 1'b1;
        wr_sel                 = op1_s;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      // Shift amount comes from param, so only port 1 is read
      OP_SHL, OP_SHR: begin
        rd_sel1                = op1_s;
        rd_en1                 = 1'b1;
        wr_en                  = 1'b1;
        wr_sel                 = op1_s;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      OP_VAL: begin
        wr_en  = 1'b1;
        wr_sel = op1_s;
      end
      OP_CMPR: begin
        rd_sel1                = op1_s;
        rd_sel2                = op2_s;
        rd_en1                 = 1'b1;
        rd_en2                 = 1'b1;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      OP_GOTO: begin
        cnt_wr_en = 1'b1;
      end
      OP_IFZ: begin
        cnt_wr_en  = status[ST_ZERO];
        add_offset = status[ST_ZERO];
      end
      OP_IFNZ: begin
        cnt_wr_en  = ~status[ST_ZERO];
        add_offset = ~status[ST_ZERO];
      end
      OP_IFEQ: begin
        cnt_wr_en  = status[ST_EQUAL];
        add_offset = status[ST_EQUAL];
      end
      OP_IFST: begin
        cnt_wr_en  = status[ST_ST];
        add_offset = status[ST_ST];
      end
      OP_IFGT: begin
        cnt_wr_en  = status[ST_GT];
        add_offset = status[ST_GT];
      end
      // Everything not listed is a reserved opcode: no side effects
      default: begin
        reserved_s = 1'b1;
      end
    endcase
  end

  // Sticky flag next-state: once a reserved opcode is seen it stays set
  always_comb begin
    illegal_op_d = illegal_op_q | reserved_s;
  end

  // Illegal-opcode flag register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op_q <= 1'b0;
    end else begin
      illegal_op_q <= illegal_op_d;
    end
  end

  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] instruction;
  logic [5:0]  status;
  logic [4:0]  opcode;
  logic [7:0]  param;
  logic [7:0]  literal_adr;
  logic [1:0]  rd_sel1, rd_sel2;
  logic        rd_en1, rd_en2, wr_en;
  logic [1:0]  wr_sel;
  logic        sel_reg_in_alu_decoder, add_offset, cnt_wr_en, stat_wr_en;
  logic        stat_reg_in_alu_decoder;
  logic [5:0]  status_out;
  logic        illegal_op;

  int tests_run;
  int tests_failed;

  decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .status(status),
    .opcode(opcode), .param(param), .literal_adr(literal_adr),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .sel_reg_in_alu_decoder(sel_reg_in_alu_decoder),
    .add_offset(add_offset), .cnt_wr_en(cnt_wr_en), .stat_wr_en(stat_wr_en),
    .stat_reg_in_alu_decoder(stat_reg_in_alu_decoder),
    .status_out(status_out), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle layout:
  // {opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2, wr_en,
  //  wr_sel, sel_reg, add_offset, cnt_wr_en, stat_wr_en, stat_reg, status_out}
  function automatic logic [40:0] actual();
    return {opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
            wr_en, wr_sel, sel_reg_in_alu_decoder, add_offset, cnt_wr_en,
            stat_wr_en, stat_reg_in_alu_decoder, status_out};
  endfunction

  // Hand-specified expectation helper for the vector table
  function automatic logic [40:0] pk(input logic [15:0] i,
      input logic [1:0] rs1, input logic [1:0] rs2, input logic re1,
      input logic re2, input logic we, input logic [1:0] ws, input logic sr,
      input logic ao, input logic cw, input logic sw);
    return {i[15:11], i[7:0], i[7:0], rs1, rs2, re1, re2, we, ws, sr, ao,
            cw, sw, 1'b1, 6'b000000};
  endfunction

  function automatic bit is_reserved(input logic [15:0] i);
    int opc;
    opc = int'(i[15:11]);
    return (opc >= 11 && opc <= 15) || (opc >= 22);
  endfunction

  // Reference model: instruction classes by opcode number
  function automatic logic [40:0] model(input logic [15:0] i,
                                        input logic [5:0] s);
    int opc;
    logic [1:0] a, b, rs1, rs2, ws;
    logic re1, re2, we, sr, ao, cw, sw;
    int bit_idx;
    logic want;
    opc = int'(i[15:11]);
    a = i[9:8];
    b = i[4:3];
    rs1 = 2'b00; rs2 = 2'b00; ws = 2'b00;
    re1 = 1'b0; re2 = 1'b0; we = 1'b0; sr = 1'b0;
    ao = 1'b0; cw = 1'b0; sw = 1'b0;
    bit_idx = 0; want = 1'b0;
    if (opc inside {1, 2, 3, 4, 6, 10}) begin
      rs1 = a; rs2 = b; re1 = 1'b1; re2 = 1'b1; sr = 1'b1; sw = 1'b1;
      if (opc != 10) begin
        we = 1'b1; ws = a;
      end
    end else if (opc == 5) begin
      rs2 = b; re2 = 1'b1; we = 1'b1; ws = a; sr = 1'b1; sw = 1'b1;
    end else if (opc == 7 || opc == 8) begin
      rs1 = a; re1 = 1'b1; we = 1'b1; ws = a; sr = 1'b1; sw = 1'b1;
    end else if (opc == 9) begin
      we = 1'b1; ws = a;
    end else if (opc == 16) begin
      cw = 1'b1;
    end else if (opc >= 17 && opc <= 21) begin
      bit_idx = (opc == 17 || opc == 18) ? 2 :
                (opc == 19) ? 3 : (opc == 20) ? 5 : 4;
      want = (opc == 18) ? 1'b0 : 1'b1;
      cw = (s[bit_idx] == want);
      ao = cw;
    end
    return {i[15:11], i[7:0], i[7:0], rs1, rs2, re1, re2, we, ws, sr, ao,
            cw, sw, 1'b1, 6'b000000};
  endfunction

  task automatic check_vec(input string name, input logic [40:0] exp);
    tests_run++;
    if (actual() !== exp) begin
      tests_failed++;
      $display("FAIL %s: outputs got %h expected %h", name, actual(), exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [5:0]  stat;
    logic [40:0] exp;
  } vec_t;

  vec_t vecs[$];
  bit   sticky_m;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    instruction  = 16'h0000;
    status       = 6'b000000;

    vecs.push_back('{16'h0000, 6'h00, pk(16'h0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'h0910, 6'h00, pk(16'h0910, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1)});
    vecs.push_back('{16'h2A00, 6'h00, pk(16'h2A00, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1)});
    vecs.push_back('{16'h4BA5, 6'h3F, pk(16'h4BA5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'h803F, 6'h00, pk(16'h803F, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)});
    vecs.push_back('{16'h8800, 6'h00, pk(16'h8800, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'h8800, 6'h04, pk(16'h8800, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{16'h9000, 6'h00, pk(16'h9000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{16'h9000, 6'h04, pk(16'h9000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'h9800, 6'h08, pk(16'h9800, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{16'h9800, 6'h37, pk(16'h9800, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'hA000, 6'h20, pk(16'hA000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{16'hA000, 6'h1F, pk(16'hA000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'hA800, 6'h10, pk(16'hA800, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{16'hA800, 6'h2F, pk(16'hA800, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{16'h3A1B, 6'h00, pk(16'h3A1B, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1)});
    vecs.push_back('{16'h5118, 6'h00, pk(16'h5118, 2'd1, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1)});
    vecs.push_back('{16'hC0FF, 6'h3F, pk(16'hC0FF, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)});

    // Reset state and combinational outputs while reset is held
    #1;
    check_bit("reset_illegal", illegal_op, 1'b0);
    check_vec("reset_nop_defaults", pk(16'h0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Table vectors, applied with reset still asserted (flag stays 0)
    for (int k = 0; k < vecs.size(); k++) begin
      instruction = vecs[k].instr;
      status      = vecs[k].stat;
      #1;
      check_vec($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Release reset on a NOP
    instruction = 16'h0000;
    status      = 6'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("nop_no_illegal", illegal_op, 1'b0);

    // Legal boundary opcodes (CMPR 01010, IFGT 10101) must not set the flag
    instruction = 16'h5000;
    @(negedge clk);
    instruction = 16'hA800;
    @(negedge clk);
    check_bit("legal_boundary_no_illegal", illegal_op, 1'b0);

    // Reserved 11000: flag only after the clock edge, sticky afterwards
    instruction = 16'hC000;
    #1;
    check_bit("illegal_before_edge", illegal_op, 1'b0);
    check_vec("reserved_defaults", pk(16'hC000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_bit("illegal_set", illegal_op, 1'b1);
    instruction = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check_bit("illegal_sticky", illegal_op, 1'b1);

    // Asynchronous clear, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("illegal_async_clear", illegal_op, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lower reserved boundary 01011 and upper-range start 10110
    instruction = 16'h5800;
    @(negedge clk);
    check_bit("illegal_01011", illegal_op, 1'b1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    instruction = 16'hB000;
    @(negedge clk);
    check_bit("illegal_10110", illegal_op, 1'b1);

    // Status-only change updates the branch outputs immediately
    instruction = 16'h8812;
    status = 6'h00;
    #1;
    check_vec("ifz_not_taken_live", model(16'h8812, 6'h00));
    status = 6'h04;
    #1;
    check_vec("ifz_taken_live", pk(16'h8812, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));

    // Randomized run against the reference model, sticky flag tracked too
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sticky_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      instruction = 16'($urandom);
      if (n < 200 && instruction[15]) instruction[14:13] = 2'b00; // favour branches/ALU early
      status = 6'($urandom);
      #1;
      check_vec($sformatf("rand%0d", n), model(instruction, status));
      check_bit($sformatf("rand_illegal%0d", n), illegal_op, sticky_m);
      sticky_m = sticky_m | is_reserved(instruction);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
